// File: rtl/inst_fetch_responder_pkg.sv
// Shared definitions for the instruction fetch responder.
// Reset levels, address masks, bus widths and FSM encodings.
package inst_fetch_responder_pkg;

  localparam logic RstnEnable  = 1'b0;
  localparam logic RstnDisable = 1'b1;

  localparam int InstBus     = 32;
  localparam int InstAddrBus = 32;

  localparam logic [31:0] KsegMask    = 32'h1fffffff;
  localparam logic [31:0] ResetVector = 32'hbfc00000;

  typedef logic [InstBus-1:0]     inst_t;
  typedef logic [InstAddrBus-1:0] iaddr_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    inst_t inst;
    logic  valid;
    logic  err;
  } resp_t;

  function automatic iaddr_t word_off(
    input iaddr_t va,
    input iaddr_t base
  );
    return ((va & KsegMask) - base) >> 2;
  endfunction

  // kseg0/kseg1 both fold onto the same physical window
  function automatic logic addr_bad(
    input iaddr_t      va,
    input iaddr_t      base,
    input int unsigned depth
  );
    iaddr_t pa;
    pa = va & KsegMask;
    return (va[1:0] != 2'b00)
      || (pa < base)
      || (word_off(va, base) >= iaddr_t'(depth));
  endfunction

endpackage

// File: rtl/inst_fetch_responder_if.sv
// Fetch bus between the PC stage and the fetch responder,
// plus the boot/test preload port of the instruction store.
interface inst_fetch_responder_if #(
  parameter int DEPTH = 1024
) ();
  import inst_fetch_responder_pkg::*;

  localparam int IW = $clog2(DEPTH);

  logic          ce;
  iaddr_t        addr;
  logic          flush;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  inst_t         wr_data;
  inst_t         inst;
  logic          inst_valid;
  logic          addr_err;
  logic          stallreq;

  modport master (
    output ce, addr, flush,
    output wr_en, wr_idx, wr_data,
    input  inst, inst_valid,
    input  addr_err, stallreq
  );

  modport slave (
    input  ce, addr, flush,
    input  wr_en, wr_idx, wr_data,
    output inst, inst_valid,
    output addr_err, stallreq
  );

endinterface

// File: rtl/inst_fetch_responder_mem_array.sv
// Instruction store: synchronous write, asynchronous read.
// Contents are deliberately not reset so a preload survives rst.
module inst_mem_array
  import inst_fetch_responder_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  inst_t                    wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output inst_t                    rd_data
);

  inst_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/inst_fetch_responder.sv
// Memory side of instruction fetch: fixed wait states,
// stall request to CTRL, flush abort and write-first bypass.
module inst_fetch_responder
  import inst_fetch_responder_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_PADDR  = 32'h1fc00000
) (
  input  logic                  clk,
  input  logic                  rst,
  inst_fetch_responder_if.slave bus
);

  localparam int         IW       = $clog2(DEPTH);
  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  function automatic logic [IW-1:0] idx_of(
    input iaddr_t va
  );
    return IW'(word_off(va, BASE_PADDR));
  endfunction

  state_e        state;
  state_e        state_n;
  logic [3:0]    cnt;
  logic [3:0]    cnt_n;
  iaddr_t        lat_addr;
  iaddr_t        lat_addr_n;
  logic          lat_valid;
  logic          lat_valid_n;
  resp_t         rsp;
  resp_t         rsp_n;

  logic [IW-1:0] lat_idx;
  inst_t         rd_data;
  inst_t         fill;
  logic          hit;
  logic          req;
  logic          req_bad;
  logic          wr_same;
  logic          wr_hit;

  inst_mem_array #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (bus.wr_en),
    .wr_idx  (bus.wr_idx),
    .wr_data (bus.wr_data),
    .rd_idx  (lat_idx),
    .rd_data (rd_data)
  );

  assign lat_idx = idx_of(lat_addr);
  assign hit     = rsp.valid & (bus.addr == lat_addr);
  assign req     = bus.ce & ~bus.flush & ~hit;
  assign req_bad = addr_bad(bus.addr, BASE_PADDR, DEPTH);
  assign wr_same = bus.wr_en & (bus.wr_idx == lat_idx);
  assign wr_hit  = wr_same & lat_valid;

  // write-first: a store update on the completion edge wins
  assign fill = wr_same ? bus.wr_data : rd_data;

  assign bus.stallreq   = bus.ce & ~hit & ~bus.flush;
  assign bus.inst       = rsp.inst;
  assign bus.inst_valid = rsp.valid;
  assign bus.addr_err   = rsp.err;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    lat_addr_n  = lat_addr;
    lat_valid_n = lat_valid;
    rsp_n       = rsp;
    if (wr_hit) begin
      rsp_n.valid = 1'b0;
    end
    unique case (state)
      IDLE: begin
        if (req) begin
          lat_addr_n  = bus.addr;
          rsp_n.valid = 1'b0;
          rsp_n.err   = 1'b0;
          unique case (1'b1)
            req_bad: begin
              rsp_n = '{inst: '0, valid: 1'b1, err: 1'b1};
              lat_valid_n = 1'b0;
            end
            default: begin
              cnt_n       = WaitInit;
              lat_valid_n = 1'b1;
              state_n     = BUSY;
            end
          endcase
        end
      end
      BUSY: begin
        unique case (1'b1)
          bus.flush: begin
            rsp_n.valid = 1'b0;
            lat_valid_n = 1'b0;
            state_n     = IDLE;
          end
          (~bus.flush & (cnt == 4'd0)): begin
            rsp_n   = '{inst: fill, valid: 1'b1, err: 1'b0};
            state_n = IDLE;
          end
          default: begin
            cnt_n = cnt - 4'd1;
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstnEnable) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_addr  <= '0;
      lat_valid <= 1'b0;
      rsp       <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      lat_addr  <= lat_addr_n;
      lat_valid <= lat_valid_n;
      rsp       <= rsp_n;
    end
  end

endmodule
